// File: rtl/stack_seq_ctrl.sv
// -----------------------------------------------------------------------------
// stack_seq_ctrl
//
// Multi-cycle sequencer for a small 32-bit stack machine. It fetches one
// instruction word per instruction from an external combinational instruction
// memory, drives an external combinational-read / synchronous-write stack
// memory, and borrows an external combinational add/subtract ALU.
//
// Instruction format: opcode = instr[31:26], imm = instr[25:0] (sign-extended).
//   0x00 NOP, 0x01 PUSH imm, 0x02 POP, 0x03 ADD, 0x04 SUB (B - A), 0x05 DUP,
//   0x3F HALT; anything else is illegal.
//
// Ports
//   clock, reset     : clock (rising edge) and asynchronous active-high reset
//   im_addr/im_data  : instruction address (= pc) and instruction word
//   st_addr/st_we/st_wdata/st_rdata : stack memory port
//   alu_op/alu_a/alu_b/alu_y        : ALU port (alu_op 0 = add, 1 = subtract)
//   sp               : occupied stack entries, 0..STACK_DEPTH
//   pc               : program counter
//   retire           : one-cycle pulse on the last cycle of each instruction
//   halted           : high in HALT and ERROR
//   err              : 0 none, 1 overflow, 2 underflow, 3 illegal opcode
//
// All outputs except im_addr are registers: each one is loaded on the edge
// that enters the state in which it must be valid.
// -----------------------------------------------------------------------------
module stack_seq_ctrl #(
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned PC_W        = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic [PC_W-1:0]                im_addr,
  input  logic [31:0]                    im_data,
  output logic [$clog2(STACK_DEPTH)-1:0] st_addr,
  output logic                           st_we,
  output logic [31:0]                    st_wdata,
  input  logic [31:0]                    st_rdata,
  output logic                           alu_op,
  output logic [31:0]                    alu_a,
  output logic [31:0]                    alu_b,
  input  logic [31:0]                    alu_y,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic [PC_W-1:0]                pc,
  output logic                           retire,
  output logic                           halted,
  output logic [1:0]                     err
);

  localparam int unsigned AW = $clog2(STACK_DEPTH);

  localparam logic [5:0] OpNop  = 6'h00;
  localparam logic [5:0] OpPush = 6'h01;
  localparam logic [5:0] OpPop  = 6'h02;
  localparam logic [5:0] OpAdd  = 6'h03;
  localparam logic [5:0] OpSub  = 6'h04;
  localparam logic [5:0] OpDup  = 6'h05;
  localparam logic [5:0] OpHalt = 6'h3F;

  localparam logic [1:0] ErrNone      = 2'd0;
  localparam logic [1:0] ErrOverflow  = 2'd1;
  localparam logic [1:0] ErrUnderflow = 2'd2;
  localparam logic [1:0] ErrIllegal   = 2'd3;

  localparam logic [AW:0] SpFull = (AW+1)'(STACK_DEPTH);
  localparam logic [AW:0] SpOne  = (AW+1)'(1);
  localparam logic [AW:0] SpTwo  = (AW+1)'(2);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StRdA,
    StRdB,
    StExec,
    StWrite,
    StHalt,
    StError
  } state_e;

  state_e      state_q;
  logic [31:0] ir_q;
  logic [31:0] a_q;

  // Decode of the held instruction register.
  logic [5:0]    opcode;
  logic [31:0]   imm_ext;
  logic [AW:0]   sp_m1;
  logic [AW-1:0] addr_m1;
  logic [AW-1:0] addr_m2;
  logic          is_legal;
  logic          is_arith;
  logic          overflow;
  logic          underflow;

  always_comb begin
    opcode   = ir_q[31:26];
    imm_ext  = {{6{ir_q[25]}}, ir_q[25:0]};
    sp_m1    = sp - SpOne;
    addr_m1  = AW'(sp - SpOne);
    addr_m2  = AW'(sp - SpTwo);
    is_arith = (opcode == OpAdd) || (opcode == OpSub);
    is_legal = 1'b0;
    case (opcode)
      OpNop, OpPush, OpPop, OpAdd, OpSub, OpDup, OpHalt: is_legal = 1'b1;
      default:                                           is_legal = 1'b0;
    endcase
    overflow  = ((opcode == OpPush) || (opcode == OpDup)) && (sp == SpFull);
    underflow = (((opcode == OpPop) || (opcode == OpDup)) && (sp == '0)) ||
                (is_arith && (sp < SpTwo));
  end

  assign im_addr = pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StFetch;
      ir_q     <= '0;
      a_q      <= '0;
      pc       <= '0;
      sp       <= '0;
      st_addr  <= '0;
      st_we    <= 1'b0;
      st_wdata <= '0;
      alu_op   <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      retire   <= 1'b0;
      halted   <= 1'b0;
      err      <= ErrNone;
    end else begin
      // Strobes default low; they are raised only on entry to their state.
      st_we  <= 1'b0;
      retire <= 1'b0;

      unique case (state_q)
        StFetch: begin
          ir_q    <= im_data;
          pc      <= pc + PC_W'(1);
          // HALT retires in DECODE, so its pulse is armed from the fetched word.
          retire  <= (im_data[31:26] == OpHalt);
          state_q <= StDecode;
        end

        StDecode: begin
          // Error checks come first so a faulting instruction never touches memory.
          if (!is_legal) begin
            err     <= ErrIllegal;
            halted  <= 1'b1;
            state_q <= StError;
          end else if (overflow) begin
            err     <= ErrOverflow;
            halted  <= 1'b1;
            state_q <= StError;
          end else if (underflow) begin
            err     <= ErrUnderflow;
            halted  <= 1'b1;
            state_q <= StError;
          end else begin
            case (opcode)
              OpNop, OpPop: begin
                retire  <= 1'b1;
                state_q <= StExec;
              end
              OpPush: begin
                st_addr  <= sp[AW-1:0];
                st_wdata <= imm_ext;
                st_we    <= 1'b1;
                retire   <= 1'b1;
                state_q  <= StWrite;
              end
              OpAdd, OpSub, OpDup: begin
                st_addr <= addr_m1;
                state_q <= StRdA;
              end
              default: begin
                // Only HALT remains after the legality check.
                halted  <= 1'b1;
                state_q <= StHalt;
              end
            endcase
          end
        end

        StRdA: begin
          a_q <= st_rdata;
          if (opcode == OpDup) begin
            st_addr  <= sp[AW-1:0];
            st_wdata <= st_rdata;
            st_we    <= 1'b1;
            retire   <= 1'b1;
            state_q  <= StWrite;
          end else begin
            st_addr <= addr_m2;
            state_q <= StRdB;
          end
        end

        StRdB: begin
          // Operand B is the second entry from the top; SUB yields B - A.
          alu_a   <= st_rdata;
          alu_b   <= a_q;
          alu_op  <= (opcode == OpSub);
          state_q <= StExec;
        end

        StExec: begin
          if (is_arith) begin
            st_addr  <= addr_m2;
            st_wdata <= alu_y;
            st_we    <= 1'b1;
            retire   <= 1'b1;
            state_q  <= StWrite;
          end else begin
            if (opcode == OpPop) begin
              sp <= sp_m1;
            end
            state_q <= StFetch;
          end
        end

        StWrite: begin
          if (is_arith) begin
            sp <= sp_m1;
          end else begin
            sp <= sp + SpOne;
          end
          state_q <= StFetch;
        end

        StHalt: begin
          state_q <= StHalt;
        end

        StError: begin
          state_q <= StError;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_seq_ctrl.sv
module tb_stack_seq_ctrl;

  localparam int unsigned Depth = 16;
  localparam int unsigned PcW   = 8;

  logic                    clock;
  logic                    reset;
  logic [PcW-1:0]          im_addr;
  logic [31:0]             im_data;
  logic [$clog2(Depth)-1:0] st_addr;
  logic                    st_we;
  logic [31:0]             st_wdata;
  logic [31:0]             st_rdata;
  logic                    alu_op;
  logic [31:0]             alu_a;
  logic [31:0]             alu_b;
  logic [31:0]             alu_y;
  logic [$clog2(Depth):0]  sp;
  logic [PcW-1:0]          pc;
  logic                    retire;
  logic                    halted;
  logic [1:0]              err;

  logic [31:0] im   [2**PcW];
  logic [31:0] smem [Depth];

  int checks   = 0;
  int failures = 0;

  stack_seq_ctrl #(
    .STACK_DEPTH(Depth),
    .PC_W       (PcW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .im_addr (im_addr),
    .im_data (im_data),
    .st_addr (st_addr),
    .st_we   (st_we),
    .st_wdata(st_wdata),
    .st_rdata(st_rdata),
    .alu_op  (alu_op),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_y   (alu_y),
    .sp      (sp),
    .pc      (pc),
    .retire  (retire),
    .halted  (halted),
    .err     (err)
  );

  // Environment: instruction ROM, stack RAM and ALU.
  assign im_data  = im[im_addr];
  assign st_rdata = smem[st_addr];
  assign alu_y    = alu_op ? (alu_a - alu_b) : (alu_a + alu_b);

  always @(posedge clock) begin
    if (st_we) smem[st_addr] <= st_wdata;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Load a program; unused locations hold HALT so a runaway pc stops.
  task automatic load(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                      input logic [31:0] p3, input logic [31:0] p4, input logic [31:0] p5);
    for (int i = 0; i < 2**PcW; i++) im[i] = 32'hFC00_0000;
    im[0] = p0; im[1] = p1; im[2] = p2; im[3] = p3; im[4] = p4; im[5] = p5;
  endtask

  // Holds reset for two clocks and releases it on a falling edge (cycle 0).
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Samples once per cycle on the falling edge; halt_cyc = -1 if budget expires.
  task automatic run(input int max_cyc, output int halt_cyc, output int n_ret, output int n_we);
    halt_cyc = -1;
    n_ret    = 0;
    n_we     = 0;
    for (int c = 0; c <= max_cyc; c++) begin
      if (retire) n_ret++;
      if (st_we) n_we++;
      if (halted) begin
        halt_cyc = c;
        break;
      end
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  int hc, nr, nw, extra;

  initial begin
    reset = 1'b1;

    // ---- ADD program, reset state, latency ----
    load(32'h0400_0022, 32'h0400_0033, 32'h0C00_0000, 32'hFC00_0000, 32'hFC00_0000,
         32'hFC00_0000);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_sp", 32'(sp), 32'h0);
    chk("rst_retire", 32'(retire), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_we", 32'(st_we), 32'h0);
    reset = 1'b0;
    run(100, hc, nr, nw);
    chk("add_halt_cycle", 32'(hc), 32'd14);
    chk("add_retires", 32'(nr), 32'd4);
    chk("add_writes", 32'(nw), 32'd3);
    chk("add_mem0", smem[0], 32'h0000_0055);
    chk("add_sp", 32'(sp), 32'd1);
    chk("add_err", 32'(err), 32'd0);
    chk("add_pc", 32'(pc), 32'd4);

    // ---- SUB wraps modulo 2^32 ----
    load(32'h0400_0005, 32'h0400_0007, 32'h1000_0000, 32'hFC00_0000, 32'hFC00_0000,
         32'hFC00_0000);
    do_reset();
    run(100, hc, nr, nw);
    chk("sub_halt_cycle", 32'(hc), 32'd14);
    chk("sub_mem0", smem[0], 32'hFFFF_FFFE);
    chk("sub_sp", 32'(sp), 32'd1);
    chk("sub_err", 32'(err), 32'd0);

    // ---- negative imm, DUP, ADD, POP, NOP ----
    load(32'h0600_0003, 32'h1400_0000, 32'h0C00_0000, 32'h0800_0000, 32'h0000_0000,
         32'hFC00_0000);
    do_reset();
    run(100, hc, nr, nw);
    chk("dup_halt_cycle", 32'(hc), 32'd21);
    chk("dup_retires", 32'(nr), 32'd6);
    chk("dup_writes", 32'(nw), 32'd3);
    chk("dup_mem0", smem[0], 32'hFC00_0006);
    chk("dup_mem1", smem[1], 32'hFE00_0003);
    chk("dup_sp", 32'(sp), 32'd0);
    chk("dup_pc", 32'(pc), 32'd6);

    // ---- overflow on the 17th PUSH ----
    for (int i = 0; i < 2**PcW; i++) im[i] = 32'hFC00_0000;
    for (int i = 0; i < 17; i++) im[i] = 32'h0400_0001;
    do_reset();
    run(200, hc, nr, nw);
    chk("ovf_halt_cycle", 32'(hc), 32'd50);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_sp", 32'(sp), 32'd16);
    chk("ovf_writes", 32'(nw), 32'd16);
    chk("ovf_retires", 32'(nr), 32'd16);
    chk("ovf_mem15", smem[15], 32'h0000_0001);
    chk("ovf_pc", 32'(pc), 32'd17);

    // ---- POP from empty stack ----
    load(32'h0800_0000, 32'hFC00_0000, 32'hFC00_0000, 32'hFC00_0000, 32'hFC00_0000,
         32'hFC00_0000);
    do_reset();
    run(100, hc, nr, nw);
    chk("popu_halt_cycle", 32'(hc), 32'd2);
    chk("popu_err", 32'(err), 32'd2);
    chk("popu_sp", 32'(sp), 32'd0);
    chk("popu_retires", 32'(nr), 32'd0);

    // ---- ADD with a single entry ----
    load(32'h0400_0009, 32'h0C00_0000, 32'hFC00_0000, 32'hFC00_0000, 32'hFC00_0000,
         32'hFC00_0000);
    do_reset();
    run(100, hc, nr, nw);
    chk("addu_halt_cycle", 32'(hc), 32'd5);
    chk("addu_err", 32'(err), 32'd2);
    chk("addu_sp", 32'(sp), 32'd1);
    chk("addu_mem0", smem[0], 32'h0000_0009);

    // ---- illegal opcode 0x07, then ERROR is absorbing ----
    load(32'h1C00_0000, 32'h0400_0001, 32'hFC00_0000, 32'hFC00_0000, 32'hFC00_0000,
         32'hFC00_0000);
    do_reset();
    run(100, hc, nr, nw);
    chk("ill_halt_cycle", 32'(hc), 32'd2);
    chk("ill_err", 32'(err), 32'd3);
    chk("ill_pc", 32'(pc), 32'd1);
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (st_we || retire) extra++;
    end
    chk("ill_absorb_activity", 32'(extra), 32'd0);
    chk("ill_absorb_pc", 32'(pc), 32'd1);
    chk("ill_absorb_sp", 32'(sp), 32'd0);
    chk("ill_absorb_halted", 32'(halted), 32'd1);
    chk("ill_absorb_err", 32'(err), 32'd3);

    // ---- reset during RD_B of ADD, then clean re-execution ----
    load(32'h0400_0001, 32'h0400_0002, 32'h0C00_0000, 32'hFC00_0000, 32'hFC00_0000,
         32'hFC00_0000);
    do_reset();
    repeat (9) begin
      @(posedge clock);
      @(negedge clock);
    end
    chk("mid_sp_before", 32'(sp), 32'd2);
    reset = 1'b1;
    #1;
    chk("mid_pc", 32'(pc), 32'd0);
    chk("mid_sp", 32'(sp), 32'd0);
    chk("mid_we", 32'(st_we), 32'd0);
    chk("mid_retire", 32'(retire), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    run(100, hc, nr, nw);
    chk("rerun_halt_cycle", 32'(hc), 32'd14);
    chk("rerun_mem0", smem[0], 32'h0000_0003);
    chk("rerun_sp", 32'(sp), 32'd1);
    chk("rerun_err", 32'(err), 32'd0);
    chk("rerun_retires", 32'(nr), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
